enemy_attack_arbiter: RTL and testbench

- Arbitrates the player's health resource among the ENEMY_NUM per-enemy gamelogic instances.
- Enemies request to attack. The block grants at most one enemy per game frame, round-robin, with a per-enemy cooldown.
- It drives each instance's Enemy_Attack_Valid, owns Player_Blood, and sequences the IDLE/PLAY/DEAD game flow.

---
 rtl/enemy_attack_arbiter_if.sv | 37 +++
 rtl/enemy_attack_arbiter.sv | 135 +++++++++++++
 tb/tb_enemy_attack_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/enemy_attack_arbiter_if.sv
// Handshake bundle between the game frame logic and the enemy attack arbiter.
// master: the side that sources frame ticks, start, godmode and attack requests.
// slave : the arbiter, which returns grants, player health and game state.
interface enemy_attack_arbiter_if #(
    parameter int ENEMY_NUM = 4
);
    logic                 game_frame_clk_rising_edge;
    logic                 Start;
    logic                 Godmode_On;
    logic [ENEMY_NUM-1:0] Attack_Req;
    logic [ENEMY_NUM-1:0] Enemy_Attack_Valid;
    logic [6:0]           Player_Blood;
    logic [1:0]           Game_State;
    logic                 Game_Over;

    modport master (
        output game_frame_clk_rising_edge,
        output Start,
        output Godmode_On,
        output Attack_Req,
        input  Enemy_Attack_Valid,
        input  Player_Blood,
        input  Game_State,
        input  Game_Over
    );

    modport slave (
        input  game_frame_clk_rising_edge,
        input  Start,
        input  Godmode_On,
        input  Attack_Req,
        output Enemy_Attack_Valid,
        output Player_Blood,
        output Game_State,
        output Game_Over
    );
endinterface

// File: rtl/enemy_attack_arbiter.sv
// Enemy attack arbiter: one round-robin grant per game frame with per-enemy
// cooldown, owns the player's health and sequences IDLE/PLAY/DEAD.
// The grant is combinational so each enemy sees it in its own tick cycle.
module enemy_attack_arbiter #(
    parameter int ENEMY_NUM         = 4,
    parameter int COOLDOWN_FRAMES   = 30,
    parameter int PLAYER_FULL_BLOOD = 100,
    parameter int ENEMY_DAMAGE      = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    enemy_attack_arbiter_if.slave bus
);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam int PW = (ENEMY_NUM > 1) ? $clog2(ENEMY_NUM) : 1;
    localparam logic [6:0]    FULL_BLOOD = 7'(PLAYER_FULL_BLOOD);
    localparam logic [6:0]    DAMAGE     = 7'(ENEMY_DAMAGE);
    localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN_FRAMES);
    localparam logic [PW-1:0] LAST_IDX   = PW'(ENEMY_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_game_over;
    logic [6:0]      r_blood;
    logic [PW-1:0]   r_ptr;

    logic [ENEMY_NUM-1:0] w_eligible;
    logic [ENEMY_NUM-1:0] w_grant;
    logic [PW-1:0]        w_winner;
    logic                 w_found;
    logic                 w_tick_play;
    logic                 w_grant_any;
    logic                 w_restart;
    logic [6:0]           w_blood_hit;
    logic [PW-1:0]        w_ptr_next;

    // Reset is gated in so a reset landing on a tick never leaks a grant.
    assign w_tick_play = bus.game_frame_clk_rising_edge && (r_state == ST_PLAY) && !Reset;
    assign w_grant_any = w_tick_play && w_found;
    assign w_restart   = bus.Start && (r_state != ST_PLAY);
    assign w_blood_hit = (r_blood <= DAMAGE) ? 7'd0 : (r_blood - DAMAGE);
    assign w_ptr_next  = (w_winner == LAST_IDX) ? '0 : (w_winner + 1'b1);

    // Rotating priority scan: first eligible index starting at the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < ENEMY_NUM; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % ENEMY_NUM;
            if (!w_found && w_eligible[idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENEMY_NUM; gi++) begin : g_enemy
            logic [CW-1:0] r_cool;

            assign w_eligible[gi] = bus.Attack_Req[gi] && (r_cool == '0);
            assign w_grant[gi]    = w_grant_any && (w_winner == PW'(gi));

            // Cooldown counter: load on grant, count down once per PLAY tick.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_cool <= '0;
                end else if (w_restart) begin
                    r_cool <= '0;
                end else if (w_tick_play) begin
                    if (w_grant[gi])
                        r_cool <= COOL_LOAD;
                    else if (r_cool != '0)
                        r_cool <= r_cool - 1'b1;
                end
            end
        end
    endgenerate

    // Game flow, player health and round-robin pointer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
            r_blood     <= FULL_BLOOD;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_state <= ST_PLAY;
                        r_blood <= FULL_BLOOD;
                        r_ptr   <= '0;
                    end
                end
                ST_PLAY: begin
                    if (w_grant_any) begin
                        r_ptr <= w_ptr_next;
                        if (!bus.Godmode_On) begin
                            r_blood <= w_blood_hit;
                            if (w_blood_hit == 7'd0) begin
                                r_state     <= ST_DEAD;
                                r_game_over <= 1'b1;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (bus.Start) begin
                        r_state     <= ST_PLAY;
                        r_game_over <= 1'b0;
                        r_blood     <= FULL_BLOOD;
                        r_ptr       <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Enemy_Attack_Valid = w_grant;
    assign bus.Player_Blood       = r_blood;
    assign bus.Game_State         = r_state;
    assign bus.Game_Over          = r_game_over;
endmodule

// File: tb/tb_enemy_attack_arbiter.sv
// Directed bench for enemy_attack_arbiter: vector tables for the round-robin
// sequences plus hand-written multi-frame sequences (cooldown, godmode,
// death/restart, mid-game reset). A second instance with 95 full health
// shares the stimulus to show saturating health.
module tb_enemy_attack_arbiter;
    localparam int N = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    enemy_attack_arbiter_if #(.ENEMY_NUM(N)) bus_a ();
    enemy_attack_arbiter_if #(.ENEMY_NUM(N)) bus_b ();

    enemy_attack_arbiter #(
        .ENEMY_NUM(N), .COOLDOWN_FRAMES(30), .PLAYER_FULL_BLOOD(100), .ENEMY_DAMAGE(10)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus_a.slave)
    );

    enemy_attack_arbiter #(
        .ENEMY_NUM(N), .COOLDOWN_FRAMES(30), .PLAYER_FULL_BLOOD(95), .ENEMY_DAMAGE(10)
    ) dut95 (
        .Clk(Clk), .Reset(Reset), .bus(bus_b.slave)
    );

    typedef struct {
        logic       start;
        logic       tick;
        logic       god;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [6:0] exp_blood;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl_rr   [8];
    vec_t tbl_wrap [4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample the combinational grant before the
    // edge, then leave the caller at posedge+1 to look at registered outputs.
    task automatic step(input logic rst, input logic start, input logic tick, input logic god,
                        input logic [3:0] req, output logic [3:0] grant);
        @(negedge Clk);
        Reset = rst;
        bus_a.Start = start; bus_a.game_frame_clk_rising_edge = tick;
        bus_a.Godmode_On = god; bus_a.Attack_Req = req;
        bus_b.Start = start; bus_b.game_frame_clk_rising_edge = tick;
        bus_b.Godmode_On = god; bus_b.Attack_Req = req;
        #2;
        grant = bus_a.Enemy_Attack_Valid;
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_vec(input string tag, input int idx, input vec_t v);
        logic [3:0] g;
        step(1'b0, v.start, v.tick, v.god, v.req, g);
        check($sformatf("%s[%0d] grant", tag, idx), 32'(g), 32'(v.exp_grant));
        check($sformatf("%s[%0d] blood", tag, idx), 32'(bus_a.Player_Blood), 32'(v.exp_blood));
        check($sformatf("%s[%0d] state", tag, idx), 32'(bus_a.Game_State), 32'(v.exp_state));
        check($sformatf("%s[%0d] over", tag, idx), 32'(bus_a.Game_Over), 32'(v.exp_state == 2'd2));
        $display("%s[%0d] req=%b tick=%0d grant=%b blood=%0d state=%0d",
                 tag, idx, v.req, v.tick, g, bus_a.Player_Blood, bus_a.Game_State);
    endtask

    task automatic do_reset();
        logic [3:0] g;
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, g);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, g);
    endtask

    initial begin
        logic [3:0] g;
        int gcount;
        int gticks [$];
        int exp_ticks [$];
        int exp_a, exp_b;
        bit dead_seen;

        tbl_rr[0] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 7'd100, 2'd1};
        tbl_rr[1] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0001, 7'd90,  2'd1};
        tbl_rr[2] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 7'd80,  2'd1};
        tbl_rr[3] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 7'd70,  2'd1};
        tbl_rr[4] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000, 7'd60,  2'd1};
        tbl_rr[5] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 7'd60,  2'd1};
        tbl_rr[6] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0000, 7'd60,  2'd1};
        tbl_rr[7] = '{1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 7'd60,  2'd1};

        tbl_wrap[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 7'd100, 2'd1};
        tbl_wrap[1] = '{1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 7'd90,  2'd1};
        tbl_wrap[2] = '{1'b0, 1'b1, 1'b0, 4'b0011, 4'b0001, 7'd80,  2'd1};
        tbl_wrap[3] = '{1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 7'd70,  2'd1};

        Reset = 1'b1;
        bus_a.Start = 0; bus_a.game_frame_clk_rising_edge = 0; bus_a.Godmode_On = 0; bus_a.Attack_Req = 0;
        bus_b.Start = 0; bus_b.game_frame_clk_rising_edge = 0; bus_b.Godmode_On = 0; bus_b.Attack_Req = 0;

        // Reset state, with requests and a tick present while in IDLE.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("reset grant", 32'(g), 32'd0);
        check("reset blood", 32'(bus_a.Player_Blood), 32'd100);
        check("reset state", 32'(bus_a.Game_State), 32'd0);
        check("reset over", 32'(bus_a.Game_Over), 32'd0);
        $display("reset: grant=%b blood=%0d state=%0d", g, bus_a.Player_Blood, bus_a.Game_State);

        // Round robin over all four, then everyone cooling.
        foreach (tbl_rr[i]) apply_vec("rr", i, tbl_rr[i]);
        for (int t = 7; t <= 31; t++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
            check($sformatf("rr cool tick%0d grant", t), 32'(g), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("rr tick32 grant", 32'(g), 32'b0001);
        check("rr tick32 blood", 32'(bus_a.Player_Blood), 32'd50);
        $display("rr tick32: grant=%b blood=%0d", g, bus_a.Player_Blood);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("rr tick33 grant", 32'(g), 32'b0010);
        check("rr tick33 blood", 32'(bus_a.Player_Blood), 32'd40);
        $display("rr tick33: grant=%b blood=%0d", g, bus_a.Player_Blood);

        // Pointer wrap: grant enemy 1 (ptr=2), let it cool, then 0011 wraps to 0.
        do_reset();
        apply_vec("wrap", 0, tbl_wrap[0]);
        apply_vec("wrap", 1, tbl_wrap[1]);
        for (int t = 0; t < 30; t++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, g);
            check("wrap idle grant", 32'(g), 32'd0);
        end
        apply_vec("wrap", 2, tbl_wrap[2]);
        apply_vec("wrap", 3, tbl_wrap[3]);

        // Godmode: 100 ticks, grants on 1/32/63/94, health untouched.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, g);
        gticks.delete();
        for (int t = 1; t <= 100; t++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, g);
            if (g != 4'b0000) begin
                gticks.push_back(t);
                check("god grant value", 32'(g), 32'b0001);
                $display("god tick%0d: grant=%b blood=%0d", t, g, bus_a.Player_Blood);
            end
        end
        exp_ticks = '{1, 32, 63, 94};
        check("god grant count", 32'(gticks.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("god grant%0d tick", k), (k < gticks.size()) ? 32'(gticks[k]) : 32'hFFFF_FFFF,
                  32'(exp_ticks[k]));
        check("god blood", 32'(bus_a.Player_Blood), 32'd100);

        // Death after ten grants; the 95 instance saturates 5 -> 0.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, g);
        exp_ticks = '{1, 2, 3, 4, 32, 33, 34, 35, 63, 64};
        gcount = 0;
        dead_seen = 0;
        for (int t = 1; t <= 80 && !dead_seen; t++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
            if (g != 4'b0000) begin
                check($sformatf("death grant%0d tick", gcount), 32'(t), 32'(exp_ticks[gcount]));
                gcount++;
                exp_a = (100 - 10 * gcount < 0) ? 0 : 100 - 10 * gcount;
                exp_b = (95 - 10 * gcount < 0) ? 0 : 95 - 10 * gcount;
                check($sformatf("death blood g%0d", gcount), 32'(bus_a.Player_Blood), 32'(exp_a));
                check($sformatf("death95 blood g%0d", gcount), 32'(bus_b.Player_Blood), 32'(exp_b));
                $display("death tick%0d: grant=%b blood=%0d blood95=%0d", t, g,
                         bus_a.Player_Blood, bus_b.Player_Blood);
                if (gcount == 10) dead_seen = 1;
            end
        end
        check("death reached 10 grants", 32'(gcount), 32'd10);
        check("death state", 32'(bus_a.Game_State), 32'd2);
        check("death over", 32'(bus_a.Game_Over), 32'd1);
        check("death95 state", 32'(bus_b.Game_State), 32'd2);
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
            check("dead grant", 32'(g), 32'd0);
            check("dead state hold", 32'(bus_a.Game_State), 32'd2);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, g);
        check("restart grant", 32'(g), 32'd0);
        check("restart state", 32'(bus_a.Game_State), 32'd1);
        check("restart over", 32'(bus_a.Game_Over), 32'd0);
        check("restart blood", 32'(bus_a.Player_Blood), 32'd100);
        check("restart95 blood", 32'(bus_b.Player_Blood), 32'd95);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("restart first grant", 32'(g), 32'b0001);
        check("restart first blood", 32'(bus_a.Player_Blood), 32'd90);
        $display("restart: grant=%b blood=%0d state=%0d", g, bus_a.Player_Blood, bus_a.Game_State);

        // Reset during a PLAY tick at health 50.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, g);
        for (int t = 1; t <= 32; t++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("midreset pre blood", 32'(bus_a.Player_Blood), 32'd50);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("midreset grant", 32'(g), 32'd0);
        check("midreset state", 32'(bus_a.Game_State), 32'd0);
        check("midreset blood", 32'(bus_a.Player_Blood), 32'd100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, g);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, g);
        check("midreset ptr0 grant", 32'(g), 32'b0001);
        $display("midreset: first grant after restart=%b blood=%0d", g, bus_a.Player_Blood);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
